// File: rtl/chan_demux_pkg.sv
// chan_demux_pkg: shared occupancy type and saturating counter helper for chan_demux.
package chan_demux_pkg;
  typedef enum logic [1:0] {OCC_EMPTY = 2'd0, OCC_ONE = 2'd1, OCC_TWO = 2'd2} occ_t;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/chan_demux_slot.sv
// chan_demux_slot: 2-entry elastic buffer; head register doubles as the output word and holds after pop.
module chan_demux_slot
  import chan_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] head_data
);
  occ_t             occ_q;
  logic [WIDTH-1:0] head_q, tail_q;
  logic             valid_q, full_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q   <= OCC_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      case (occ_q)
        OCC_EMPTY: if (push) begin
          occ_q   <= OCC_ONE;
          head_q  <= push_data;
          valid_q <= 1'b1;
        end
        OCC_ONE: if (push && pop) head_q <= push_data;
        else if (push) begin
          occ_q  <= OCC_TWO;
          tail_q <= push_data;
          full_q <= 1'b1;
        end else if (pop) begin
          occ_q   <= OCC_EMPTY;
          valid_q <= 1'b0;
        end
        OCC_TWO: if (pop) begin
          occ_q  <= OCC_ONE;
          head_q <= tail_q;
          full_q <= 1'b0;
        end
        default: begin
          occ_q   <= OCC_EMPTY;
          valid_q <= 1'b0;
          full_q  <= 1'b0;
        end
      endcase
    end
  end
  assign full      = full_q;
  assign valid     = valid_q;
  assign head_data = head_q;
endmodule

// File: rtl/chan_demux.sv
// chan_demux: 1-to-NCHAN stream demux with per-channel 2-entry buffers and drop counter.
// Defining CHAN_DEMUX_STATS_EN adds stat_count, a saturating per-channel output-transfer counter.
module chan_demux
  import chan_demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCHAN = 4,
  parameter int CHW   = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CHW-1:0]         in_chan,
  input  logic [WIDTH-1:0]       in_data,
  output logic [NCHAN-1:0]       out_valid,
  input  logic [NCHAN-1:0]       out_ready,
  output logic [NCHAN*WIDTH-1:0] out_data,
  output logic [15:0]            drop_count
`ifdef CHAN_DEMUX_STATS_EN
  ,
  output logic [NCHAN*16-1:0]    stat_count
`endif
);
  localparam int NPAD = 1 << CHW;
  logic [NCHAN-1:0] full, push, pop;
  logic [NPAD-1:0]  full_x;
  logic             bad, accept;
  logic [15:0]      drop_q;
  // Tags past NCHAN are always accepted so a bad producer can never stall the bus.
  assign bad = {1'b0, in_chan} >= (CHW+1)'(NCHAN);
  always_comb begin
    full_x             = '0;
    full_x[NCHAN-1:0] = full;
  end
  assign in_ready = bad || !full_x[in_chan];
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid & out_ready;
  for (genvar k = 0; k < NCHAN; k++) begin : g_ch
    assign push[k] = accept && !bad && (in_chan == CHW'(k));
    chan_demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .push      (push[k]),
      .push_data (in_data),
      .pop       (pop[k]),
      .full      (full[k]),
      .valid     (out_valid[k]),
      .head_data (out_data[k*WIDTH +: WIDTH])
    );
`ifdef CHAN_DEMUX_STATS_EN
    logic [15:0] stat_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) stat_q <= '0;
      else if (pop[k]) stat_q <= sat_inc(stat_q);
    end
    assign stat_count[k*16 +: 16] = stat_q;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= '0;
    else if (accept && bad) drop_q <= sat_inc(drop_q);
  end
  assign drop_count = drop_q;
endmodule

// File: tb/tb_chan_demux.sv
// tb_chan_demux: directed and random checks of chan_demux against a queue-based reference model.
module tb_chan_demux;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [1:0]  in_chan = '0;
  logic [7:0]  in_data = '0;
  logic [3:0]  out_valid, out_ready = '0;
  logic [31:0] out_data;
  logic [15:0] drop_count;
  logic        v3 = 1'b0, ready3;
  logic [1:0]  ch3 = '0;
  logic [7:0]  d3 = '0;
  logic [2:0]  ov3, ordy3 = '0;
  logic [23:0] od3;
  logic [15:0] drop3;
`ifdef CHAN_DEMUX_STATS_EN
  logic [63:0] st4;
  logic [47:0] st3;
  logic [15:0] stat_m [4];
`endif
  int n_chk = 0, n_fail = 0;
  logic [7:0] mq [4][$];
  logic [7:0] last [4];

  always #5 clk = ~clk;

  chan_demux #(.WIDTH(8), .NCHAN(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_count(drop_count)
`ifdef CHAN_DEMUX_STATS_EN
    , .stat_count(st4)
`endif
  );

  chan_demux #(.WIDTH(8), .NCHAN(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(ready3), .in_chan(ch3),
    .in_data(d3), .out_valid(ov3), .out_ready(ordy3), .out_data(od3),
    .drop_count(drop3)
`ifdef CHAN_DEMUX_STATS_EN
    , .stat_count(st3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      last[k] = 8'h00;
`ifdef CHAN_DEMUX_STATS_EN
      stat_m[k] = 16'h0;
`endif
    end
  endtask

  // One clock cycle on the 4-channel DUT, starting and ending at a falling edge.
  task automatic cyc(input logic v, input logic [1:0] ch, input logic [7:0] d, input logic [3:0] ordy);
    logic       acc;
    logic [3:0] pops;
    in_valid = v; in_chan = ch; in_data = d; out_ready = ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(mq[ch].size() < 2));
    acc = v && (mq[ch].size() < 2);
    for (int k = 0; k < 4; k++) pops[k] = ordy[k] && (mq[k].size() > 0);
    @(posedge clk);
    for (int k = 0; k < 4; k++) if (pops[k]) begin
      void'(mq[k].pop_front());
`ifdef CHAN_DEMUX_STATS_EN
      if (stat_m[k] != 16'hFFFF) stat_m[k] = stat_m[k] + 16'd1;
`endif
    end
    if (acc) mq[ch].push_back(d);
    for (int k = 0; k < 4; k++) if (mq[k].size() > 0) last[k] = mq[k][0];
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("out_valid", 32'(out_valid[k]), 32'(mq[k].size() > 0));
      chk("out_data", 32'(out_data[k*8 +: 8]), 32'(last[k]));
`ifdef CHAN_DEMUX_STATS_EN
      chk("stat_count", 32'(st4[k*16 +: 16]), 32'(stat_m[k]));
`endif
    end
    chk("drop_count", 32'(drop_count), 32'h0);
  endtask

  task automatic cyc3(input logic v, input logic [1:0] ch, input logic [7:0] d);
    v3 = v; ch3 = ch; d3 = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_drop", 32'(drop_count), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    // single word
    cyc(1'b1, 2'd1, 8'hA5, 4'b0000);
    chk("single_valid", 32'(out_valid), 32'h2);
    chk("single_data", 32'(out_data[15:8]), 32'hA5);
    cyc(1'b0, 2'd1, 8'h00, 4'b0010);
    // backpressure on channel 0
    cyc(1'b1, 2'd0, 8'h11, 4'b0000);
    cyc(1'b1, 2'd0, 8'h22, 4'b0000);
    cyc(1'b1, 2'd0, 8'h33, 4'b0000);
    #1 chk("bp_ready_low", 32'(in_ready), 32'h0);
    @(negedge clk);
    chk("bp_head11", 32'(out_data[7:0]), 32'h11);
    cyc(1'b1, 2'd0, 8'h33, 4'b0001);
    chk("bp_head22", 32'(out_data[7:0]), 32'h22);
    cyc(1'b1, 2'd0, 8'h33, 4'b0001);
    chk("bp_head33", 32'(out_data[7:0]), 32'h33);
    cyc(1'b0, 2'd0, 8'h00, 4'b0001);
    chk("bp_empty", 32'(out_valid[0]), 32'h0);
    chk("bp_hold", 32'(out_data[7:0]), 32'h33);
    // push+pop at ONE on channel 3
    cyc(1'b1, 2'd3, 8'h01, 4'b0000);
    cyc(1'b1, 2'd3, 8'h02, 4'b1000);
    chk("pp_valid", 32'(out_valid[3]), 32'h1);
    chk("pp_data", 32'(out_data[31:24]), 32'h02);
    cyc(1'b0, 2'd3, 8'h00, 4'b1000);
    chk("pp_one_only", 32'(out_valid[3]), 32'h0);
    // random traffic
    for (int i = 0; i < 1500; i++)
      cyc(1'(($urandom % 4) != 0), 2'($urandom), 8'($urandom), 4'($urandom));
    // reset mid-stream with channel 2 full
    cyc(1'b0, 2'd0, 8'h00, 4'b1111);
    cyc(1'b0, 2'd0, 8'h00, 4'b1111);
    cyc(1'b1, 2'd2, 8'h77, 4'b0000);
    cyc(1'b1, 2'd2, 8'h78, 4'b0000);
    chk("pre_rst_ready", 32'(in_ready), 32'h0);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_drop", 32'(drop_count), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1 chk("post_rst_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom), 2'($urandom), 8'($urandom), 4'($urandom));
    // invalid tag on the 3-channel DUT
    for (int i = 0; i < 5; i++) begin
      v3 = 1'b1; ch3 = 2'd3; d3 = 8'($urandom);
      #1 chk("inv_ready", 32'(ready3), 32'h1);
      @(posedge clk);
      @(negedge clk);
      chk("inv_no_valid", 32'(ov3), 32'h0);
    end
    chk("inv_drop5", 32'(drop3), 32'd5);
    cyc3(1'b1, 2'd2, 8'h5A);
    chk("n3_valid", 32'(ov3), 32'h4);
    chk("n3_data", 32'(od3[23:16]), 32'h5A);
    chk("n3_drop_same", 32'(drop3), 32'd5);
    v3 = 1'b1; ch3 = 2'd3;
    repeat (65530) @(posedge clk);
    @(negedge clk);
    chk("drop_max", 32'(drop3), 32'hFFFF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drop_sat", 32'(drop3), 32'hFFFF);
    v3 = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/chan_demux.md
Name: chan_demux

Overview:
Sequential 1-to-N stream demultiplexer, the distributing counterpart of the team's combining multiplexer primitive.
- Accepts one tagged word per cycle on a valid/ready input and routes it to one of NCHAN output channels.
- Each channel has a 2-entry elastic buffer, so the block sustains full throughput and breaks the ready path.
- Sits between a shared bus producer and per-channel consumers.

Parameters:
WIDTH, 8, data word width in bits
NCHAN, 4, number of output channels (2..16)
CHW, $clog2(NCHAN) (min 1), width of channel tag

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  input word present
in_ready  output  1  block accepts input this cycle
in_chan  input  CHW  destination channel tag
in_data  input  WIDTH  input word
out_valid  output  NCHAN  per-channel word present
out_ready  input  NCHAN  per-channel consumer accepts
out_data  output  NCHAN*WIDTH  per-channel head word; channel k in bits [k*WIDTH +: WIDTH]
drop_count  output  16  count of words dropped for tag >= NCHAN

Behaviour:
- Reset (async assert, sync release): every channel occupancy = 0; out_valid = 0; out_data = 0; drop_count = 0.
- Input transfer occurs when in_valid && in_ready on a rising clk.
- Output transfer on channel k occurs when out_valid[k] && out_ready[k].
- Per-channel state:
  - EMPTY (occ 0) -> ONE on push.
  - ONE (occ 1) -> TWO on push without pop; -> EMPTY on pop without push; stays ONE on push+pop, head takes the new word.
  - TWO (occ 2) -> ONE on pop; a push is impossible (ready low).
- in_ready = (in_chan >= NCHAN) || occ[in_chan] != 2.
  - Combinational from in_chan and registered state only; no path from out_ready to in_ready.
  - in_ready is defined even when in_valid = 0.
- Latency: an accepted word appears on out_data/out_valid of its channel the next cycle when that channel was EMPTY.
- Ordering: per-channel FIFO order is preserved. No ordering guarantee across channels.
- Invalid tag (in_chan >= NCHAN, only when NCHAN is not a power of 2):
  - word accepted and discarded;
  - drop_count increments, saturating at 16'hFFFF.
- out_data[k] holds its last value while out_valid[k] = 0; it is not cleared on pop.
- Channels are fully independent; pops on several channels in one cycle are all honoured.
- Reset mid-operation: all buffered words are lost; out_valid falls asynchronously with rst.
- Throughput: 1 word/cycle sustained when the targeted consumer holds out_ready high.

Optional Feature:
CHAN_DEMUX_STATS_EN
- Defined:
  - adds output port stat_count, width NCHAN*16;
  - one 16-bit counter per channel, incremented on each output transfer of that channel, saturating at 16'hFFFF;
  - counters reset to 0 by rst.
- Undefined: the port and counters do not exist; all other behaviour is identical.

Decomposition:
- Package chan_demux_pkg:
  - typedef occ_t (2-bit: OCC_EMPTY = 0, OCC_ONE = 1, OCC_TWO = 2);
  - constant CNT_MAX = 16'hFFFF;
  - function sat_inc(16-bit) for drop and stat counters.
- Sub-module chan_demux_slot: one 2-entry elastic buffer.
  - Parameter WIDTH.
  - Ports clk, rst, push, push_data, pop, full, valid, head_data.
  - Instantiated NCHAN times by a generate loop.
- Top level holds tag decode, in_ready mux, drop counter and optional stats.

Test Plan:
- Reset: assert rst mid-stream with channel 2 holding 2 words -> out_valid = 4'b0000 immediately, drop_count = 0, in_ready = 1 after release.
- Single word: in_chan = 1, in_data = 8'hA5, out_ready = 0 -> next cycle out_valid = 4'b0010, out_data[15:8] = 8'hA5.
- Backpressure: push 8'h11, 8'h22, 8'h33 to channel 0 with out_ready[0] = 0 -> in_ready drops after 2 pushes, the third word is held. Raise out_ready -> channel 0 delivers 11, 22, 33 in order.
- Push+pop at ONE: channel 3 holds 8'h01, push 8'h02 while popping -> occ stays 1, out_data[31:24] = 8'h02.
- Invalid tag (NCHAN = 3): in_chan = 3 for 5 cycles -> in_ready = 1 throughout, no out_valid change, drop_count = 5. Preload drop_count to 16'hFFFF -> it stays at 16'hFFFF.
- Stats (macro defined): 10 pops on channel 2 and 3 pops on channel 0 -> stat_count[47:32] = 10, stat_count[15:0] = 3, other counters 0.
